dmux_stream: RTL and testbench
==============================

# dmux_stream

Parametrised, registered 1-to-NWAY demultiplexer with valid/ready flow control per output channel, generalising the combinational 8-way bit demux to multi-bit words, arbitrary channel count, independent per-channel back-pressure and a broadcast mode. It sits between a single producer (e.g. the CPU data bus or a memory read port) and NWAY consumers (RAM banks, peripherals). Each channel has one output holding register, so a stalled consumer never blocks traffic to other channels.

## Interface
- WIDTH, 16: data word width in bits (1..64).
- NWAY, 8: number of output channels (2..16; need not be a power of two).
- SELW, $clog2(NWAY): select width; derived, not overridden.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  SELW  destination channel index.
- in_bcast  input  1  1 = deliver word to every channel; in_sel ignored.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- out_data  output  NWAY*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- out_valid  output  NWAY  channel i holding register full.
- out_ready  input  NWAY  consumer i takes its word this cycle.
- err_sel  output  1  one-cycle pulse: word with in_sel >= NWAY was discarded.

## Operation
- Per channel i: holding register data_q[i], flag full_q[i]; out_data/out_valid drive them directly (registered outputs, no combinational path from in_* to out_*).
- free[i] = !full_q[i] | out_ready[i] (slot empty or draining this cycle).
- in_ready, unicast (in_bcast=0): in_sel < NWAY ? free[in_sel] : 1.
- in_ready, broadcast (in_bcast=1): AND of free[i] over all channels (all-or-nothing; never partial delivery).
- Accept = in_valid & in_ready. On accept, unicast, legal sel: data_q[in_sel] <= in_data, full_q[in_sel] <= 1.
- On accept, broadcast: every data_q[i] <= in_data, full_q[i] <= 1.
- On accept, unicast, in_sel >= NWAY: word dropped, no channel state changes, err_sel = 1 next cycle.
- Channel drain: if full_q[i] & out_ready[i] and channel i not written this cycle, full_q[i] <= 0.
- Simultaneous drain and write on same channel: write wins, full_q[i] stays 1, new data loaded (back-to-back throughput 1 word/cycle per channel).
- out_ready[i] while full_q[i]=0: ignored.
- in_data/in_sel/in_bcast are don't-care when in_valid=0; they may change while in_valid=1 and in_ready=0 (no producer hold requirement enforced by the block).
- Channels not addressed keep state; drains on all channels are independent and concurrent.

## Timing
- Reset (clk edge with reset=1): full_q = 0 for all channels, data_q = 0, err_sel = 0. Hence out_valid = 0, out_data = 0 the cycle after. reset overrides any concurrent accept or drain; a word in flight is lost.
- in_ready is combinational from in_sel, in_bcast, full_q, out_ready; valid during reset as computed from current state but accepts in that cycle have no effect.
- Latency: word accepted on edge k appears on out_data/out_valid immediately after edge k (1 cycle).
- Throughput: 1 word/cycle into any channel whose consumer holds out_ready=1; 1 word/cycle broadcast if all consumers ready.
- err_sel: high exactly the one cycle after the illegal accept edge; consecutive illegal accepts produce continuous high.

## Test plan
- Reset then unicast WIDTH=16, NWAY=8: in_data=0xBEEF, in_sel=5, in_valid=1, all out_ready=0 -> next cycle out_valid=8'b0010_0000, channel 5 data=0xBEEF, others 0; second word to sel 5 -> in_ready=0, channel 5 keeps 0xBEEF.
- Back-to-back streaming: words 1..10 to sel 2, out_ready[2]=1 constantly -> in_ready stays 1, channel 2 shows 1..10 on consecutive cycles, out_valid[2] never drops.
- Independence: channel 3 full and stalled; send 0x0011 to sel 0 -> accepted, channel 0 valid next cycle while channel 3 unchanged.
- Broadcast: in_bcast=1, data 0xA5A5, channel 6 full and out_ready[6]=0 -> in_ready=0, no channel changes; raise out_ready[6] -> accepted, all 8 channels show 0xA5A5, out_valid=8'hFF.
- Illegal select, NWAY=6: in_sel=7, in_valid=1 -> in_ready=1, err_sel=1 next cycle only, out_valid unchanged.
- Reset mid-operation: channels 1 and 4 full, assert reset with in_valid=1 to sel 2 -> next cycle out_valid=0, all out_data=0, err_sel=0.

Source files
------------

// File: rtl/dmux_stream.sv
// Registered 1-to-NWAY stream demux with per-channel holding registers,
// independent valid/ready back-pressure and an all-or-nothing broadcast.
module dmux_stream #(
   parameter  int WIDTH = 16,
   parameter  int NWAY  = 8,
   localparam int SELW  = $clog2(NWAY)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [SELW-1:0]       in_sel,
   input  logic                  in_bcast,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [NWAY*WIDTH-1:0] out_data,
   output logic [NWAY-1:0]       out_valid,
   input  logic [NWAY-1:0]       out_ready,
   output logic                  err_sel
);

   logic [NWAY-1:0][WIDTH-1:0] data_q;
   logic [NWAY-1:0]            full_q;
   logic [NWAY-1:0]            free;
   logic [NWAY-1:0]            wr;
   logic                       legal;
   logic                       sel_free;
   logic                       acc;

   assign free  = ~full_q | out_ready;
   assign legal = int'(in_sel) < NWAY;

   always_comb begin
      sel_free = 1'b0;
      for (int i = 0; i < NWAY; i++) begin
         if (int'(in_sel) == i) sel_free = free[i];
      end
   end

   // An out-of-range select is always accepted so the bad word is flushed.
   assign in_ready = in_bcast ? &free : (!legal || sel_free);
   assign acc      = in_valid && in_ready;

   always_comb begin
      wr = '0;
      for (int i = 0; i < NWAY; i++) begin
         wr[i] = acc && (in_bcast || int'(in_sel) == i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         full_q  <= '0;
         err_sel <= 1'b0;
      end else begin
         for (int i = 0; i < NWAY; i++) begin
            if (wr[i]) begin
               data_q[i] <= in_data;
               full_q[i] <= 1'b1;
            end else if (out_ready[i]) begin
               full_q[i] <= 1'b0;
            end
         end
         err_sel <= acc && !in_bcast && !legal;
      end
   end

   assign out_data  = data_q;
   assign out_valid = full_q;

endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream: an 8-way instance for routing and flow
// control, a 6-way instance for out-of-range selects.
module tb_dmux_stream;

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   a_data;
   logic [2:0]    a_sel;
   logic          a_bcast;
   logic          a_valid;
   logic          a_ready;
   logic [127:0]  a_odata;
   logic [7:0]    a_ovalid;
   logic [7:0]    a_oready;
   logic          a_err;

   logic          b_reset;
   logic [15:0]   b_data;
   logic [2:0]    b_sel;
   logic          b_bcast;
   logic          b_valid;
   logic          b_ready;
   logic [95:0]   b_odata;
   logic [5:0]    b_ovalid;
   logic [5:0]    b_oready;
   logic          b_err;

   int checks = 0;
   int errors = 0;

   logic [127:0] exp_a;

   always #5 clk = ~clk;

   dmux_stream #(.WIDTH(16), .NWAY(8)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .in_data   (a_data),
      .in_sel    (a_sel),
      .in_bcast  (a_bcast),
      .in_valid  (a_valid),
      .in_ready  (a_ready),
      .out_data  (a_odata),
      .out_valid (a_ovalid),
      .out_ready (a_oready),
      .err_sel   (a_err)
   );

   dmux_stream #(.WIDTH(16), .NWAY(6)) dut_b (
      .clk       (clk),
      .reset     (b_reset),
      .in_data   (b_data),
      .in_sel    (b_sel),
      .in_bcast  (b_bcast),
      .in_valid  (b_valid),
      .in_ready  (b_ready),
      .out_data  (b_odata),
      .out_valid (b_ovalid),
      .out_ready (b_oready),
      .err_sel   (b_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; b_reset = 1'b1;
      a_valid = 1'b0; a_bcast = 1'b0; a_sel = '0; a_data = '0;
      a_oready = '0;
      b_valid = 1'b0; b_bcast = 1'b0; b_sel = '0; b_data = '0;
      b_oready = '0;
      tick();
      tick();
      reset = 1'b0; b_reset = 1'b0;
      checks++;
      if (a_ovalid !== 8'h00) begin
         errors++;
         $display("FAIL reset_valid got %h want 00", a_ovalid);
      end
      checks++;
      if (a_odata !== 128'h0) begin
         errors++;
         $display("FAIL reset_data got %h want 0", a_odata);
      end
      checks++;
      if (a_err !== 1'b0 || b_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err got %b/%b want 0/0", a_err, b_err);
      end
   endtask

   task automatic test_unicast();
      a_data = 16'hBEEF; a_sel = 3'd5; a_valid = 1'b1;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
         errors++;
         $display("FAIL uni_ready got %b want 1", a_ready);
      end
      tick();
      exp_a = '0;
      exp_a[5*16 +: 16] = 16'hBEEF;
      checks++;
      if (a_ovalid !== 8'b0010_0000) begin
         errors++;
         $display("FAIL uni_valid got %b want 00100000", a_ovalid);
      end
      checks++;
      if (a_odata !== exp_a) begin
         errors++;
         $display("FAIL uni_data got %h want %h", a_odata, exp_a);
      end
      a_data = 16'h1234;
      #1;
      checks++;
      if (a_ready !== 1'b0) begin
         errors++;
         $display("FAIL uni_stall_ready got %b want 0", a_ready);
      end
      tick();
      checks++;
      if (a_odata !== exp_a || a_ovalid !== 8'h20) begin
         errors++;
         $display("FAIL uni_hold got %h/%h want %h/20",
                  a_odata, a_ovalid, exp_a);
      end
      a_valid = 1'b0;
      a_oready = 8'h20;
      tick();
      a_oready = '0;
      checks++;
      if (a_ovalid !== 8'h00) begin
         errors++;
         $display("FAIL uni_drain got %h want 00", a_ovalid);
      end
   endtask

   task automatic test_back_to_back();
      a_sel = 3'd2; a_oready = 8'h04; a_valid = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         a_data = 16'(k);
         #1;
         checks++;
         if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready[%0d] got %b want 1", k, a_ready);
         end
         tick();
         checks++;
         if (a_odata[2*16 +: 16] !== 16'(k) || a_ovalid[2] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_word[%0d] got %h/%b want %h/1", k,
                     a_odata[2*16 +: 16], a_ovalid[2], 16'(k));
         end
      end
      a_valid = 1'b0;
      tick();
      a_oready = '0;
      checks++;
      if (a_ovalid !== 8'h00) begin
         errors++;
         $display("FAIL b2b_drain got %h want 00", a_ovalid);
      end
   endtask

   task automatic test_independence();
      a_data = 16'h0033; a_sel = 3'd3; a_valid = 1'b1;
      tick();
      a_data = 16'h0011; a_sel = 3'd0;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
         errors++;
         $display("FAIL ind_ready got %b want 1", a_ready);
      end
      tick();
      a_valid = 1'b0;
      checks++;
      if (a_ovalid !== 8'h09) begin
         errors++;
         $display("FAIL ind_valid got %h want 09", a_ovalid);
      end
      checks++;
      if (a_odata[0 +: 16] !== 16'h0011 ||
          a_odata[3*16 +: 16] !== 16'h0033) begin
         errors++;
         $display("FAIL ind_data got %h/%h want 0011/0033",
                  a_odata[0 +: 16], a_odata[3*16 +: 16]);
      end
   endtask

   task automatic test_broadcast();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      a_data = 16'h0066; a_sel = 3'd6; a_valid = 1'b1;
      tick();
      a_data = 16'hA5A5; a_bcast = 1'b1; a_sel = 3'd1;
      #1;
      checks++;
      if (a_ready !== 1'b0) begin
         errors++;
         $display("FAIL bc_block_ready got %b want 0", a_ready);
      end
      tick();
      exp_a = '0;
      exp_a[6*16 +: 16] = 16'h0066;
      checks++;
      if (a_ovalid !== 8'h40 || a_odata !== exp_a) begin
         errors++;
         $display("FAIL bc_blocked got %h/%h want 40/%h",
                  a_ovalid, a_odata, exp_a);
      end
      a_oready = 8'h40;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
         errors++;
         $display("FAIL bc_ready got %b want 1", a_ready);
      end
      tick();
      a_valid = 1'b0; a_bcast = 1'b0; a_oready = '0;
      for (int i = 0; i < 8; i++) exp_a[i*16 +: 16] = 16'hA5A5;
      checks++;
      if (a_ovalid !== 8'hFF || a_odata !== exp_a) begin
         errors++;
         $display("FAIL bc_all got %h/%h want FF/%h",
                  a_ovalid, a_odata, exp_a);
      end
      a_oready = 8'hFF;
      tick();
      a_oready = '0;
   endtask

   task automatic test_illegal();
      b_data = 16'h0101; b_sel = 3'd1; b_valid = 1'b1;
      tick();
      b_data = 16'hDEAD; b_sel = 3'd7;
      #1;
      checks++;
      if (b_ready !== 1'b1) begin
         errors++;
         $display("FAIL ill_ready got %b want 1", b_ready);
      end
      tick();
      checks++;
      if (b_err !== 1'b1 || b_ovalid !== 6'b000010) begin
         errors++;
         $display("FAIL ill_err got %b/%b want 1/000010",
                  b_err, b_ovalid);
      end
      b_sel = 3'd6;
      tick();
      checks++;
      if (b_err !== 1'b1) begin
         errors++;
         $display("FAIL ill_err_run got %b want 1", b_err);
      end
      b_valid = 1'b0;
      tick();
      checks++;
      if (b_err !== 1'b0 || b_odata[16 +: 16] !== 16'h0101 ||
          b_ovalid !== 6'b000010) begin
         errors++;
         $display("FAIL ill_after got %b/%h/%b want 0/0101/000010",
                  b_err, b_odata[16 +: 16], b_ovalid);
      end
      b_sel = 3'd7; b_valid = 1'b1; b_reset = 1'b1;
      tick();
      b_valid = 1'b0; b_reset = 1'b0;
      checks++;
      if (b_err !== 1'b0 || b_ovalid !== 6'h00) begin
         errors++;
         $display("FAIL ill_reset got %b/%b want 0/000000",
                  b_err, b_ovalid);
      end
   endtask

   task automatic test_reset_mid();
      a_data = 16'h1111; a_sel = 3'd1; a_valid = 1'b1;
      tick();
      a_data = 16'h4444; a_sel = 3'd4;
      tick();
      checks++;
      if (a_ovalid !== 8'h12) begin
         errors++;
         $display("FAIL mid_fill got %h want 12", a_ovalid);
      end
      a_data = 16'h7777; a_sel = 3'd2; reset = 1'b1;
      tick();
      reset = 1'b0; a_valid = 1'b0;
      checks++;
      if (a_ovalid !== 8'h00 || a_odata !== 128'h0 || a_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got %h/%h/%b want 00/0/0",
                  a_ovalid, a_odata, a_err);
      end
   endtask

   initial begin
      test_reset();
      test_unicast();
      test_back_to_back();
      test_independence();
      test_broadcast();
      test_illegal();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
